// File: rtl/sram_ctrl_if_v2_if.sv
// ============================================================================
//  Module      : sram_ctrl_if_v2_if
//  Description : Request/acknowledge bus between the AHB slave front end and
//                the SRAM control block. The master modport belongs to the
//                front end. The slave modport belongs to sram_ctrl_if_v2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_ctrl_if_v2_if #(
   parameter int AHB_DWIDTH = 32
);
   logic                  ahbsram_req;
   logic                  ahbsram_write;
   logic [2:0]            ahbsram_size;
   logic [19:0]           ahbsram_addr;
   logic [AHB_DWIDTH-1:0] ahbsram_wdata;
   logic                  sramahb_ack;
   logic [AHB_DWIDTH-1:0] sramahb_rdata;
   logic                  sramahb_err;

   modport master (
      output ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata,
      input  sramahb_ack, sramahb_rdata, sramahb_err
   );

   modport slave (
      input  ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata,
      output sramahb_ack, sramahb_rdata, sramahb_err
   );
endinterface

`default_nettype wire

// File: rtl/sram_ctrl_if_v2.sv
// ============================================================================
//  Module      : sram_ctrl_if_v2
//  Description : Single-beat SRAM control interface. It captures an AHB-side
//                request and drives registered byte-lane write strobes or a
//                read strobe. It waits out the memory read latency, then
//                returns a one-cycle acknowledge with the read data.
//                Optional macro SRAMCTRL_RANGE_CHK_EN: a word address at or
//                above DEPTH is answered with an error and never reaches the
//                memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_ctrl_if_v2 #(
   parameter int AHB_DWIDTH = 32,
   parameter int MEM_AWIDTH = 16,
   parameter int DEPTH      = 512,
   parameter int RD_LATENCY = 1,
   localparam int NUM_BYTES = AHB_DWIDTH / 8
) (
   input  wire logic                  HCLK,
   input  wire logic                  HRESETN,
   sram_ctrl_if_v2_if.slave           ahb,
   input  wire logic                  mem_busy,
   output logic [NUM_BYTES-1:0]       mem_wen,
   output logic                       mem_ren,
   output logic [MEM_AWIDTH-1:0]      mem_addr,
   output logic [AHB_DWIDTH-1:0]      mem_wdata,
   input  wire logic [AHB_DWIDTH-1:0] mem_rdata
);

   localparam int L  = $clog2(NUM_BYTES);
   localparam int CW = 3;

`ifdef SRAMCTRL_RANGE_CHK_EN
   localparam bit RANGE_CHK = 1'b1;
`else
   localparam bit RANGE_CHK = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HOLD = 3'd1,
      WR   = 3'd2,
      RD   = 3'd3,
      ACK  = 3'd4
   } state_t;

   state_t state, state_nxt;

   // Captured request, used when the access is issued from HOLD
   logic          cap_write;
   logic [2:0]    cap_size;
   logic [19:0]   cap_addr;
   logic [CW-1:0] cnt;
   logic          err_pend;

   // Request view at the issue point: live inputs in IDLE, captured copy otherwise
   logic          sel_write;
   logic [2:0]    sel_size;
   logic [19:0]   sel_addr;
   logic [19:0]   sel_word;
   logic          range_err;

   // Next values of the registered outputs and control
   logic                 capture;
   logic                 issue;
   logic                 load_rdata;
   logic [NUM_BYTES-1:0] wen_nxt;
   logic                 ren_nxt;
   logic                 ack_nxt;
   logic                 err_nxt;
   logic                 err_pend_nxt;
   logic [CW-1:0]        cnt_nxt;

   // Lanes covered by an access of 2^size bytes; low address bits below the size are ignored
   function automatic logic [NUM_BYTES-1:0] lane_mask(input logic [2:0] size,
                                                      input logic [L-1:0] offset);
      logic [NUM_BYTES-1:0] mask;
      mask = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (32'(size) >= L)
            mask[i] = 1'b1;
         else
            mask[i] = ((L'(i) >> size) == (offset >> size));
      end
      return mask;
   endfunction

   // Choose between the live request (IDLE) and the captured one (HOLD)
   always_comb begin
      sel_write = cap_write;
      sel_size  = cap_size;
      sel_addr  = cap_addr;
      if (state == IDLE) begin
         sel_write = ahb.ahbsram_write;
         sel_size  = ahb.ahbsram_size;
         sel_addr  = ahb.ahbsram_addr;
      end
   end

   assign sel_word  = sel_addr >> L;
   // With checking disabled the address simply wraps into MEM_AWIDTH
   assign range_err = RANGE_CHK & ({12'd0, sel_word} >= 32'(DEPTH));

   // State register
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode and next values of every registered output
   always_comb begin
      state_nxt    = state;
      capture      = 1'b0;
      issue        = 1'b0;
      load_rdata   = 1'b0;
      wen_nxt      = '0;
      ren_nxt      = 1'b0;
      ack_nxt      = 1'b0;
      err_nxt      = 1'b0;
      err_pend_nxt = err_pend;
      cnt_nxt      = cnt;

      case (state)
         IDLE: begin
            if (ahb.ahbsram_req) begin
               capture = 1'b1;
               if (mem_busy)
                  state_nxt = HOLD;
               else
                  issue = 1'b1;
            end
         end
         HOLD: begin
            if (!mem_busy)
               issue = 1'b1;
         end
         WR: begin
            ack_nxt   = 1'b1;
            err_nxt   = err_pend;
            state_nxt = ACK;
         end
         RD: begin
            if (cnt == '0) begin
               load_rdata = 1'b1;
               ack_nxt    = 1'b1;
               state_nxt  = ACK;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         ACK: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // An out-of-range access passes through WR without a strobe so its ack
      // lands on the same cycle as a write would
      if (issue) begin
         err_pend_nxt = range_err;
         if (range_err) begin
            state_nxt = WR;
         end else if (sel_write) begin
            state_nxt = WR;
            wen_nxt   = lane_mask(sel_size, sel_addr[L-1:0]);
         end else begin
            state_nxt = RD;
            ren_nxt   = 1'b1;
            cnt_nxt   = CW'(RD_LATENCY);
         end
      end
   end

   // Registered outputs, captured request and latency counter
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         cap_write         <= 1'b0;
         cap_size          <= '0;
         cap_addr          <= '0;
         cnt               <= '0;
         err_pend          <= 1'b0;
         mem_wen           <= '0;
         mem_ren           <= 1'b0;
         mem_addr          <= '0;
         mem_wdata         <= '0;
         ahb.sramahb_ack   <= 1'b0;
         ahb.sramahb_err   <= 1'b0;
         ahb.sramahb_rdata <= '0;
      end else begin
         cnt             <= cnt_nxt;
         err_pend        <= err_pend_nxt;
         mem_wen         <= wen_nxt;
         mem_ren         <= ren_nxt;
         ahb.sramahb_ack <= ack_nxt;
         ahb.sramahb_err <= err_nxt;
         if (capture) begin
            cap_write <= ahb.ahbsram_write;
            cap_size  <= ahb.ahbsram_size;
            cap_addr  <= ahb.ahbsram_addr;
            mem_addr  <= MEM_AWIDTH'(ahb.ahbsram_addr >> L);
            mem_wdata <= ahb.ahbsram_wdata;
         end
         if (load_rdata)
            ahb.sramahb_rdata <= mem_rdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sram_ctrl_if_v2.sv
// ============================================================================
//  Module      : tb_sram_ctrl_if_v2
//  Description : Self-checking bench for sram_ctrl_if_v2 (64-bit path,
//                read latency 3). Expected strobes and acks are queued when a
//                request is driven. They are checked when the DUT produces
//                them. Honours SRAMCTRL_RANGE_CHK_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_ctrl_if_v2;

   localparam int DW    = 64;
   localparam int NB    = DW / 8;
   localparam int LB    = 3;
   localparam int AW    = 16;
   localparam int DEPTH = 512;
   localparam int RDL   = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mem_busy;
   logic [NB-1:0] mem_wen;
   logic          mem_ren;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   always #5 clk = ~clk;

   sram_ctrl_if_v2_if #(.AHB_DWIDTH(DW)) ahb ();

   sram_ctrl_if_v2 #(
      .AHB_DWIDTH(DW), .MEM_AWIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(RDL)
   ) dut (
      .HCLK(clk), .HRESETN(rst_n), .ahb(ahb), .mem_busy(mem_busy),
      .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // ---------------- external memory stand-in ----------------
   logic [DW-1:0] tb_mem [256];
   logic [DW-1:0] rd_word = '0;

   always @(posedge clk) begin
      if (mem_ren) rd_word <= tb_mem[mem_addr[7:0]];
      for (int b = 0; b < NB; b++)
         if (mem_wen[b]) tb_mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
   end
   assign mem_rdata = rd_word;

   // ---------------- scoreboard ----------------
   typedef struct {
      int            cyc;
      logic [NB-1:0] wen;
      logic          ren;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } strobe_t;

   typedef struct {
      int            cyc;
      logic          err;
      logic [DW-1:0] rdata;
   } ack_t;

   strobe_t strobe_q[$];
   ack_t    ack_q[$];
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] last_rdata = '0;
   int cyc = 0;
   int total_cnt = 0;
   int bad_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference lane selection: aligned offset of a 2^size access within the word
   function automatic logic [NB-1:0] exp_lanes(input logic [2:0] size, input logic [19:0] addr);
      int nb;
      int off;
      nb = 1 << size;
      if (nb >= NB) return '1;
      off = (int'(addr) % NB) / nb * nb;
      return NB'((1 << nb) - 1) << off;
   endfunction

   // Monitor: every strobe and every ack must match the head of its queue
   strobe_t mon_s;
   ack_t    mon_a;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_wen != '0 || mem_ren) begin
            if (strobe_q.size() == 0) begin
               chk_eq("strobe_unexpected", 64'({mem_wen, mem_ren}), 64'd0);
            end else begin
               mon_s = strobe_q.pop_front();
               chk_eq("strobe_cycle", 64'(cyc), 64'(mon_s.cyc));
               chk_eq("mem_wen", 64'(mem_wen), 64'(mon_s.wen));
               chk_eq("mem_ren", 64'(mem_ren), 64'(mon_s.ren));
               chk_eq("mem_addr", 64'(mem_addr), 64'(mon_s.addr));
               if (!mon_s.ren) chk_eq("mem_wdata", mem_wdata, mon_s.wdata);
            end
         end
         if (ahb.sramahb_ack) begin
            if (ack_q.size() == 0) begin
               chk_eq("ack_unexpected", 64'(ahb.sramahb_ack), 64'd0);
            end else begin
               mon_a = ack_q.pop_front();
               chk_eq("ack_cycle", 64'(cyc), 64'(mon_a.cyc));
               chk_eq("ack_err", 64'(ahb.sramahb_err), 64'(mon_a.err));
               chk_eq("ack_rdata", ahb.sramahb_rdata, mon_a.rdata);
            end
         end
      end
   end

   // Drive one request (called at a negedge), queue its expectations, wait for its ack
   task automatic do_req(input logic wr, input logic [2:0] size, input logic [19:0] addr,
                         input logic [DW-1:0] wdata, input int busy, input bit busy_late,
                         input logic [NB-1:0] force_wen, input bit use_force);
      strobe_t s;
      ack_t    a;
      int      n;
      int      iss;
      int      idx;
      logic    err;
      logic [NB-1:0] lanes;
      bit      seen;
      n   = cyc + 1;
      iss = n + busy;
      err = 1'b0;
`ifdef SRAMCTRL_RANGE_CHK_EN
      err = ((addr >> LB) >= 20'(DEPTH));
`endif
      lanes = use_force ? force_wen : exp_lanes(size, addr);
      idx   = int'((addr >> LB) & 20'hFF);
      if (!err) begin
         s.cyc   = iss;
         s.ren   = !wr;
         s.wen   = wr ? lanes : '0;
         s.addr  = AW'(addr >> LB);
         s.wdata = wdata;
         strobe_q.push_back(s);
         if (wr) begin
            for (int b = 0; b < NB; b++)
               if (lanes[b]) ref_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
         end else begin
            last_rdata = ref_mem[idx];
         end
      end
      a.cyc   = (wr || err) ? iss + 1 : iss + 1 + RDL;
      a.err   = err;
      a.rdata = last_rdata;
      ack_q.push_back(a);

      ahb.ahbsram_req   = 1'b1;
      ahb.ahbsram_write = wr;
      ahb.ahbsram_size  = size;
      ahb.ahbsram_addr  = addr;
      ahb.ahbsram_wdata = wdata;
      mem_busy = (busy > 0);
      repeat (busy) @(negedge clk);
      mem_busy = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (busy_late) mem_busy = 1'b1;
         if (ahb.sramahb_ack) seen = 1'b1;
      end
      if (!seen) chk_eq("ack_timeout", 64'(ahb.sramahb_ack), 64'd1);
      // req stays high through the edge that closes ACK
      @(negedge clk);
      ahb.ahbsram_req = 1'b0;
      mem_busy = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk_eq({tag, "_ack"},   64'(ahb.sramahb_ack), 64'd0);
      chk_eq({tag, "_err"},   64'(ahb.sramahb_err), 64'd0);
      chk_eq({tag, "_rdata"}, ahb.sramahb_rdata, 64'd0);
      chk_eq({tag, "_wen"},   64'(mem_wen), 64'd0);
      chk_eq({tag, "_ren"},   64'(mem_ren), 64'd0);
      chk_eq({tag, "_addr"},  64'(mem_addr), 64'd0);
      chk_eq({tag, "_wdata"}, mem_wdata, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
      $fatal(1);
   end

   initial begin
      strobe_t s;
      for (int i = 0; i < 256; i++) begin
         tb_mem[i]  = '0;
         ref_mem[i] = '0;
      end
      mem_busy          = 1'b0;
      ahb.ahbsram_req   = 1'b0;
      ahb.ahbsram_write = 1'b0;
      ahb.ahbsram_size  = '0;
      ahb.ahbsram_addr  = '0;
      ahb.ahbsram_wdata = '0;

      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_outputs_zero("post_reset");

      // Directed: full word write/read, lane strobes, misaligned size
      do_req(1, 3'd3, 20'h00010, 64'hA5A5_1234_DEAD_BEEF, 0, 0, '0, 0);
      do_req(0, 3'd3, 20'h00010, '0, 0, 0, '0, 0);
      do_req(1, 3'd0, 20'h0000D, 64'h0000_5A00_0000_0000, 0, 0, 8'b0010_0000, 1);
      do_req(1, 3'd1, 20'h00006, 64'hBEEF_0000_0000_0000, 0, 0, 8'b1100_0000, 1);
      do_req(1, 3'd2, 20'h0001E, 64'hCAFE_F00D_1111_2222, 0, 0, 8'b1111_0000, 1);
      do_req(0, 3'd3, 20'h00008, '0, 0, 0, '0, 0);
      do_req(0, 3'd3, 20'h00000, '0, 0, 0, '0, 0);
      do_req(0, 3'd3, 20'h00018, '0, 0, 0, '0, 0);
      // Busy stalls before issue, and busy ignored after issue
      do_req(0, 3'd3, 20'h00010, '0, 2, 0, '0, 0);
      do_req(1, 3'd3, 20'h00020, 64'h0123_4567_89AB_CDEF, 1, 0, '0, 0);
      do_req(0, 3'd3, 20'h00020, '0, 0, 1, '0, 0);
      do_req(1, 3'd3, 20'h00028, 64'h7777_8888_9999_AAAA, 0, 1, '0, 0);
      // Address wraps above MEM_AWIDTH; oversize HSIZE enables every lane
      do_req(1, 3'd3, 20'h80030, 64'h5555_6666_7777_8888, 0, 0, '0, 0);
      do_req(0, 3'd3, 20'h00030, '0, 0, 0, '0, 0);
      do_req(1, 3'd5, 20'h00039, 64'hFEDC_BA98_7654_3210, 0, 0, 8'hFF, 1);
      do_req(0, 3'd2, 20'h0003C, '0, 0, 0, '0, 0);

      // Random mix of sizes, directions and stalls
      for (int t = 0; t < 24; t++)
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 20'($urandom_range(0, 20'h7FF)),
                {$urandom, $urandom}, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), '0, 0);

`ifdef SRAMCTRL_RANGE_CHK_EN
      do_req(0, 3'd3, 20'(DEPTH * NB), '0, 0, 0, '0, 0);
      do_req(1, 3'd3, 20'(DEPTH * NB + 8), 64'h1111_2222_3333_4444, 1, 0, '0, 0);
      do_req(0, 3'd3, 20'h00010, '0, 0, 0, '0, 0);
`endif

      // Reset during the read countdown: no ack, outputs clear at once
      ahb.ahbsram_req   = 1'b1;
      ahb.ahbsram_write = 1'b0;
      ahb.ahbsram_size  = 3'd3;
      ahb.ahbsram_addr  = 20'h00010;
      s.cyc   = cyc + 1;
      s.ren   = 1'b1;
      s.wen   = '0;
      s.addr  = AW'(20'h00010 >> LB);
      s.wdata = '0;
      strobe_q.push_back(s);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("async_reset");
      ahb.ahbsram_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_rdata = '0;
      repeat (8) @(negedge clk);

      // Service resumes normally after the abandoned access
      do_req(1, 3'd3, 20'h00040, 64'h0F0F_0F0F_F0F0_F0F0, 0, 0, '0, 0);
      do_req(0, 3'd3, 20'h00040, '0, 0, 0, '0, 0);
      repeat (4) @(negedge clk);

      chk_eq("strobe_queue_left", 64'(strobe_q.size()), 64'd0);
      chk_eq("ack_queue_left", 64'(ack_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

`default_nettype wire
